vector_writeback_seq: RTL and testbench
=======================================

Name: vector_writeback_seq

Overview:
- Parametrised successor to the SIMD writeback/memory stage.
- Retires one vector instruction at a time. Each instruction is one of: ALU-result writeback, immediate broadcast, vector load from data memory, or vector store.
- Memory traffic is serialised over MEM_PORTS lanes per beat, so any VEC_SIZE/element width is supported with a narrow memory.
- Sits between the execute pipe register and the register-file write port.

Parameters:
- VEC_SIZE, 4, lanes per vector.
- REG_SIZE, 16, bits per register lane.
- MEM_DATA, 8, bits per memory element; must be <= REG_SIZE.
- MEM_PORTS, 2, lanes accessed per memory beat; VEC_SIZE % MEM_PORTS == 0.
- MEM_DEPTH, 256, elements in data memory; power of two.
- ADDR_W, 16, address operand width.
- RD_W, 4, destination register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept an instruction.
- in_src  in  2  wb_src_t operation select.
- in_rd  in  RD_W  destination tag.
- in_addr  in  ADDR_W  base element address for load/store.
- in_imm  in  REG_SIZE  immediate.
- in_alu  in  VEC_SIZE x REG_SIZE  ALU result.
- in_store  in  VEC_SIZE x REG_SIZE  store data; low MEM_DATA bits are used.
- out_valid  out  1  one-cycle retire pulse.
- wb_en  out  1  register-file write enable; qualified by out_valid.
- wb_rd  out  RD_W  destination tag.
- wb_data  out  VEC_SIZE x REG_SIZE  writeback vector.

Behaviour:
- Reset (async, active-high): state IDLE; out_valid=0, wb_en=0, wb_rd=0, wb_data=0, beat counter=0, in_ready=1. Memory contents are not cleared.
- Handshake: an instruction is accepted on an edge where in_valid && in_ready. in_ready=1 only in IDLE. in_valid while busy is ignored and never queued.
- Beat count: B = VEC_SIZE/MEM_PORTS.
- FSM states: IDLE, ACCESS, DRAIN.
- IDLE transitions:
  - WB_ALU/WB_IMM: register result, stay IDLE.
  - WB_MEM/WB_STORE: latch in_addr, in_store, in_rd, in_src; enter ACCESS with beat=0.
- ACCESS (one beat per cycle): beat k covers lanes k*MEM_PORTS .. k*MEM_PORTS+MEM_PORTS-1.
  - Lane i uses element address (base+i) mod MEM_DEPTH; addresses wrap.
  - Store: writes memory at the end of the beat.
  - Load: presents the read address; the synchronous read returns data the next cycle, captured into lane slots.
  - After beat B-1: store returns to IDLE; load goes to DRAIN.
- DRAIN (load only): capture the final beat's data, then return to IDLE.
- Latency, counted from the acceptance edge e0:
  - ALU/IMM: out_valid high in the cycle after e0.
  - Store: out_valid at e0+B with wb_en=0.
  - Load: out_valid at e0+B+1 with wb_en=1.
  - A new instruction may be accepted on the edge that ends the out_valid cycle.
- Data rules:
  - WB_ALU: wb_data = in_alu.
  - WB_IMM: in_imm broadcast to every lane.
  - WB_MEM: each lane = loaded element extended to REG_SIZE.
  - WB_STORE: wb_data holds its previous value.
- Outputs: wb_rd/wb_data hold until the next retire. out_valid and wb_en drop after one cycle.
- Reset mid-operation: aborts immediately; no further writes. Beats already written stay in memory; a beat in progress at the reset edge is not written.

Optional Feature:
- Macro: VECTOR_WB_SIGN_EXT_LOAD_EN.
- Defined: loaded elements are sign-extended from MEM_DATA to REG_SIZE.
- Undefined: loaded elements are zero-extended.
- Store, ALU and IMM paths are unaffected.

Decomposition:
- Package vector_wb_pkg:
  - wb_src_t enum: WB_MEM=0, WB_ALU=1, WB_IMM=2, WB_STORE=3.
  - wb_state_t enum: IDLE, ACCESS, DRAIN.
  - Beat-count helper function.
- Sub-module vector_data_memory: MEM_PORTS-wide synchronous-read, synchronous-write RAM with MEM_PORTS independent address/data/write-enable lanes, depth MEM_DEPTH.

Test Plan:
1. Reset and ALU path: after reset, out_valid=0, wb_data=0, in_ready=1. Then in_src=WB_ALU, in_alu={4,3,2,1}, in_rd=5 → next cycle out_valid=1, wb_en=1, wb_rd=5, wb_data={4,3,2,1}.
2. Immediate broadcast: in_src=WB_IMM, in_imm=0x00A5 → next cycle all four lanes = 0x00A5.
3. Store then load: store addr 0x10, in_store={0x0080,0x00FF,0x0056,0x1234} (lane3..0) → retire at e0+2 with wb_en=0; mem[0x10..0x13]=34,56,FF,80. Then load 0x10 → retire at e0+3 with wb_data={0x0080,0x00FF,0x0056,0x0034}. With VECTOR_WB_SIGN_EXT_LOAD_EN defined: lane3=0xFF80, lane2=0xFFFF.
4. Wrap-around: store at 0x00FF → lane0 written to 0xFF, lanes1..3 to 0x00..0x02; a load from 0x00FF returns the same vector.
5. Busy and back-to-back: in_valid held during a load → in_ready=0 and the extra request is ignored; a second instruction is accepted on the edge ending out_valid.
6. Reset mid-store: assert rst after beat 0 of a store to 0x20 → only 0x20/0x21 written, 0x22/0x23 unchanged; next cycle in_ready=1 and out_valid=0.

Source files
------------

// File: rtl/vector_writeback_seq_pkg.sv
// ---------------------------------------------------------------------------
// vector_wb_pkg
// Shared types and helpers for the vector writeback sequencer.
//   wb_src_t   : operation select carried with each instruction
//   wb_state_t : sequencer FSM states
//   beat_count : memory beats needed to move one vector
//   beat_width : width of a counter that indexes those beats (min 1 bit)
// ---------------------------------------------------------------------------
package vector_wb_pkg;

    typedef enum logic [1:0] {
        WB_MEM   = 2'd0,
        WB_ALU   = 2'd1,
        WB_IMM   = 2'd2,
        WB_STORE = 2'd3
    } wb_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2
    } wb_state_t;

    function automatic int beat_count(input int vec_size, input int mem_ports);
        return vec_size / mem_ports;
    endfunction

    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vector_writeback_seq_if.sv
// ---------------------------------------------------------------------------
// vector_writeback_seq_if
// Instruction-in / writeback-out bundle of the vector writeback sequencer.
//   master : execute-side driver (offers instructions, observes retire)
//   slave  : the sequencer itself
// Signals: in_valid/in_ready handshake, in_src/in_rd/in_addr/in_imm/in_alu/
// in_store instruction payload, out_valid/wb_en/wb_rd/wb_data retire port.
// ---------------------------------------------------------------------------
interface vector_writeback_seq_if #(
    parameter int VEC_SIZE = 4,
    parameter int REG_SIZE = 16,
    parameter int ADDR_W   = 16,
    parameter int RD_W     = 4
) ();
    import vector_wb_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    wb_src_t                            in_src;
    logic [RD_W-1:0]                    in_rd;
    logic [ADDR_W-1:0]                  in_addr;
    logic [REG_SIZE-1:0]                in_imm;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]  in_alu;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]  in_store;
    logic                               out_valid;
    logic                               wb_en;
    logic [RD_W-1:0]                    wb_rd;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]  wb_data;

    modport master (
        output in_valid, in_src, in_rd, in_addr, in_imm, in_alu, in_store,
        input  in_ready, out_valid, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_src, in_rd, in_addr, in_imm, in_alu, in_store,
        output in_ready, out_valid, wb_en, wb_rd, wb_data
    );

endinterface

// File: rtl/vector_writeback_seq_data_memory.sv
// ---------------------------------------------------------------------------
// vector_data_memory
// MEM_PORTS-lane data RAM, synchronous write and registered read.
//   clk     : clock
//   i_addr  : per-lane element address
//   i_wdata : per-lane write data
//   i_we    : per-lane write enable
//   o_rdata : per-lane read data, valid the cycle after i_addr
// Contents are never reset. A read of an address written on the same edge
// returns the old contents.
// ---------------------------------------------------------------------------
module vector_data_memory #(
    parameter int MEM_PORTS = 2,
    parameter int MEM_DATA  = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                               clk,
    input  logic [MEM_PORTS-1:0][AW-1:0]       i_addr,
    input  logic [MEM_PORTS-1:0][MEM_DATA-1:0] i_wdata,
    input  logic [MEM_PORTS-1:0]               i_we,
    output logic [MEM_PORTS-1:0][MEM_DATA-1:0] o_rdata
);
    localparam int PW = (MEM_PORTS > 1) ? $clog2(MEM_PORTS) : 1;

    logic [MEM_DATA-1:0]               r_mem [MEM_DEPTH];
    logic [MEM_PORTS-1:0][MEM_DATA-1:0] r_rdata;

    // All lanes share one process so the array has a single writer.
    always_ff @(posedge clk) begin
        for (int p = 0; p < MEM_PORTS; p++) begin
            if (i_we[PW'(p)]) begin
                r_mem[i_addr[PW'(p)]] <= i_wdata[PW'(p)];
            end
            r_rdata[PW'(p)] <= r_mem[i_addr[PW'(p)]];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vector_writeback_seq.sv
// ---------------------------------------------------------------------------
// vector_writeback_seq
// Retires one vector instruction at a time: ALU writeback, immediate
// broadcast, vector load or vector store. Memory traffic moves MEM_PORTS
// lanes per beat, so a vector takes VEC_SIZE/MEM_PORTS beats.
//   clk : clock
//   rst : asynchronous active-high reset (memory contents survive)
//   bus : vector_writeback_seq_if.slave (instruction in, retire out)
// Build option: define VECTOR_WB_SIGN_EXT_LOAD_EN to sign-extend loaded
// elements; otherwise they are zero-extended.
// ---------------------------------------------------------------------------
module vector_writeback_seq
    import vector_wb_pkg::*;
#(
    parameter int VEC_SIZE  = 4,
    parameter int REG_SIZE  = 16,
    parameter int MEM_DATA  = 8,
    parameter int MEM_PORTS = 2,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 16,
    parameter int RD_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_writeback_seq_if.slave bus
);
    localparam int BEATS  = beat_count(VEC_SIZE, MEM_PORTS);
    localparam int BEAT_W = beat_width(BEATS);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    wb_state_t                          r_state, w_state_next;
    logic [BEAT_W-1:0]                  r_beat;
    logic [MEM_AW-1:0]                  r_addr;
    logic [VEC_SIZE-1:0][MEM_DATA-1:0]  r_store, w_store_shift, w_in_store_lo;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_buf, w_buf_next, w_imm_vec;
    logic [RD_W-1:0]                    r_rd;
    wb_src_t                            r_src;
    logic                               r_cap_valid;
    logic                               r_out_valid, r_wb_en;
    logic [RD_W-1:0]                    r_wb_rd;
    logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_wb_data;
    logic                               w_accept, w_last_beat, w_mem_we, w_in_ready;
    logic [MEM_PORTS-1:0][MEM_AW-1:0]   w_mem_addr;
    logic [MEM_PORTS-1:0][MEM_DATA-1:0] w_mem_wdata, w_mem_rdata;
    logic [MEM_PORTS-1:0]               w_mem_we_vec;
    logic [VEC_SIZE-1:0]                w_unused_store_hi;
    logic                               w_unused_addr_hi;

    function automatic logic [REG_SIZE-1:0] extend_elem(input logic [MEM_DATA-1:0] d);
        logic [REG_SIZE-1:0] v;
`ifdef VECTOR_WB_SIGN_EXT_LOAD_EN
        v = {REG_SIZE{d[MEM_DATA-1]}};
`else
        v = '0;
`endif
        v[MEM_DATA-1:0] = d;
        return v;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_last_beat  = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid && (bus.in_src == WB_MEM || bus.in_src == WB_STORE))
                    w_state_next = ACCESS;
            end
            ACCESS: begin
                // Leaving ACCESS asynchronously on reset drops the write
                // enable before the edge that would finish the current beat.
                w_mem_we = (r_src == WB_STORE);
                if (r_beat == LAST_BEAT) begin
                    w_last_beat  = 1'b1;
                    w_state_next = (r_src == WB_MEM) ? DRAIN : IDLE;
                end
            end
            DRAIN:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- memory lanes ----------------
    // The store vector and load buffer shift by MEM_PORTS lanes per beat, so
    // memory port p always pairs with vector slot p and no lane mux is needed.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_PORTS; gi++) begin : g_port
            assign w_mem_addr[gi]   = r_addr + MEM_AW'(gi);
            assign w_mem_wdata[gi]  = r_store[gi];
            assign w_mem_we_vec[gi] = w_mem_we;
        end

        for (gi = 0; gi < VEC_SIZE; gi++) begin : g_lane
            assign w_in_store_lo[gi] = bus.in_store[gi][MEM_DATA-1:0];
            assign w_imm_vec[gi]     = bus.in_imm;
            if (gi < VEC_SIZE - MEM_PORTS) begin : g_shift
                assign w_store_shift[gi] = r_store[gi+MEM_PORTS];
                assign w_buf_next[gi]    = r_buf[gi+MEM_PORTS];
            end else begin : g_fill
                // Newly read beat enters at the top; after the last capture
                // the first beat has shifted down into lanes 0..MEM_PORTS-1.
                assign w_store_shift[gi] = '0;
                assign w_buf_next[gi]    = extend_elem(w_mem_rdata[gi-(VEC_SIZE-MEM_PORTS)]);
            end
            if (REG_SIZE > MEM_DATA) begin : g_hi
                assign w_unused_store_hi[gi] = ^bus.in_store[gi][REG_SIZE-1:MEM_DATA];
            end else begin : g_nohi
                assign w_unused_store_hi[gi] = 1'b0;
            end
        end

        if (ADDR_W > MEM_AW) begin : g_addr_hi
            assign w_unused_addr_hi = ^bus.in_addr[ADDR_W-1:MEM_AW];
        end else begin : g_addr_nohi
            assign w_unused_addr_hi = 1'b0;
        end
    endgenerate

    vector_data_memory #(
        .MEM_PORTS (MEM_PORTS),
        .MEM_DATA  (MEM_DATA),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .i_we    (w_mem_we_vec),
        .o_rdata (w_mem_rdata)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_addr      <= '0;
            r_store     <= '0;
            r_buf       <= '0;
            r_rd        <= '0;
            r_src       <= WB_ALU;
            r_cap_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_wb_en     <= 1'b0;
            // Read data for the beat presented last cycle arrives now.
            r_cap_valid <= (r_state == ACCESS) && (r_src == WB_MEM);
            if (r_cap_valid) r_buf <= w_buf_next;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (bus.in_src)
                            WB_ALU: begin
                                r_out_valid <= 1'b1;
                                r_wb_en     <= 1'b1;
                                r_wb_rd     <= bus.in_rd;
                                r_wb_data   <= bus.in_alu;
                            end
                            WB_IMM: begin
                                r_out_valid <= 1'b1;
                                r_wb_en     <= 1'b1;
                                r_wb_rd     <= bus.in_rd;
                                r_wb_data   <= w_imm_vec;
                            end
                            default: begin
                                r_addr  <= bus.in_addr[MEM_AW-1:0];
                                r_store <= w_in_store_lo;
                                r_rd    <= bus.in_rd;
                                r_src   <= bus.in_src;
                                r_beat  <= '0;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    r_beat  <= w_last_beat ? '0 : r_beat + 1'b1;
                    r_addr  <= r_addr + MEM_AW'(MEM_PORTS);
                    r_store <= w_store_shift;
                    // A store retires without touching the register file.
                    if (w_last_beat && r_src == WB_STORE) r_out_valid <= 1'b1;
                end
                DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_wb_en     <= 1'b1;
                    r_wb_rd     <= r_rd;
                    r_wb_data   <= w_buf_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;

endmodule

// File: tb/tb_vector_writeback_seq.sv
module tb_vector_writeback_seq;
    import vector_wb_pkg::*;

    localparam int VEC = 4, REG = 16, MD = 8, MP = 2, DEPTH = 256, AW = 16, RDW = 4;
    typedef logic [VEC-1:0][REG-1:0] vec_t;
    typedef struct {
        int              cyc;
        logic            en;
        logic            chk_rd;
        logic [RDW-1:0]  rd;
        vec_t            data;
        string           tag;
    } exp_t;

`ifdef VECTOR_WB_SIGN_EXT_LOAD_EN
    localparam logic [15:0] X80 = 16'hFF80;
    localparam logic [15:0] XFF = 16'hFFFF;
`else
    localparam logic [15:0] X80 = 16'h0080;
    localparam logic [15:0] XFF = 16'h00FF;
`endif
    localparam vec_t ST10   = {16'h0080, 16'h00FF, 16'h0056, 16'h1234};
    localparam vec_t LOAD10 = {X80, XFF, 16'h0056, 16'h0034};
    localparam vec_t STFF   = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    localparam vec_t ST20A  = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
    localparam vec_t ST20B  = {16'h0099, 16'h0088, 16'h0077, 16'h0066};
    localparam vec_t LOAD20 = {16'h0011, 16'h0022, 16'h0077, 16'h0066};
    localparam vec_t ZERO   = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t exp_last = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vector_writeback_seq_if #(.VEC_SIZE(VEC), .REG_SIZE(REG), .ADDR_W(AW), .RD_W(RDW)) bus ();

    vector_writeback_seq #(
        .VEC_SIZE(VEC), .REG_SIZE(REG), .MEM_DATA(MD), .MEM_PORTS(MP),
        .MEM_DEPTH(DEPTH), .ADDR_W(AW), .RD_W(RDW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int latency(input wb_src_t src);
        case (src)
            WB_STORE: return 2;   // B beats
            WB_MEM:   return 3;   // B beats + drain
            default:  return 0;   // retire pulse follows the acceptance edge
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input wb_src_t src, input logic [RDW-1:0] rd, input logic [AW-1:0] addr,
                         input logic [REG-1:0] imm, input vec_t alu, input vec_t st,
                         input vec_t exp_data, input string tag);
        exp_t e;
        int   waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
        bus.in_src   = src;
        bus.in_rd    = rd;
        bus.in_addr  = addr;
        bus.in_imm   = imm;
        bus.in_alu   = alu;
        bus.in_store = st;
        bus.in_valid = 1'b1;
        e.cyc    = cyc + 1 + latency(src);
        e.en     = (src != WB_STORE);
        e.chk_rd = (src != WB_STORE);
        e.rd     = rd;
        e.data   = (src == WB_STORE) ? exp_last : exp_data;
        e.tag    = tag;
        if (src != WB_STORE) exp_last = exp_data;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every retire pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_retire", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.tag, "_wb_en"}, 64'(bus.wb_en), 64'(e.en));
                if (e.chk_rd) chk({e.tag, "_wb_rd"}, 64'(bus.wb_rd), 64'(e.rd));
                chk({e.tag, "_wb_data"}, 64'(bus.wb_data), 64'(e.data));
                $display("retire %s cycle=%0d wb_en=%0b wb_rd=%0d wb_data=%h",
                         e.tag, cyc, bus.wb_en, bus.wb_rd, bus.wb_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_src   = WB_ALU;
        bus.in_rd    = '0;
        bus.in_addr  = '0;
        bus.in_imm   = '0;
        bus.in_alu   = '0;
        bus.in_store = '0;

        // 1. reset state, then ALU path
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_wb_en",     64'(bus.wb_en),     64'd0);
        chk("rst_wb_rd",     64'(bus.wb_rd),     64'd0);
        chk("rst_wb_data",   64'(bus.wb_data),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        rst = 1'b0;
        @(negedge clk);
        issue(WB_ALU, 4'd5, 16'h0, 16'h0, {16'd4, 16'd3, 16'd2, 16'd1}, ZERO,
              {16'd4, 16'd3, 16'd2, 16'd1}, "alu");

        // 2. immediate broadcast
        issue(WB_IMM, 4'd6, 16'h0, 16'h00A5, ZERO, ZERO,
              {16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5}, "imm");

        // 3. store then load
        issue(WB_STORE, 4'd1, 16'h0010, 16'h0, ZERO, ST10, ZERO, "store10");
        issue(WB_MEM,   4'd7, 16'h0010, 16'h0, ZERO, ZERO, LOAD10, "load10");

        // 4. address wrap-around
        issue(WB_STORE, 4'd2, 16'h00FF, 16'h0, ZERO, STFF, ZERO, "storeFF");
        issue(WB_MEM,   4'd8, 16'h00FF, 16'h0, ZERO, ZERO, STFF, "loadFF");
        drain("t4");

        // 5. busy: request held during a load, accepted on the edge ending out_valid
        begin
            exp_t e;
            bus.in_src   = WB_MEM;
            bus.in_rd    = 4'd9;
            bus.in_addr  = 16'h0010;
            bus.in_valid = 1'b1;
            e.cyc = cyc + 1 + 3; e.en = 1'b1; e.chk_rd = 1'b1; e.rd = 4'd9;
            e.data = LOAD10; e.tag = "busy_load";
            sb.push_back(e);
            e.cyc = cyc + 1 + 4; e.en = 1'b1; e.chk_rd = 1'b1; e.rd = 4'd10;
            e.data = {16'h0040, 16'h0030, 16'h0020, 16'h0010}; e.tag = "held_alu";
            sb.push_back(e);
            exp_last = e.data;
            @(posedge clk);
            #1;
            bus.in_src = WB_ALU;
            bus.in_rd  = 4'd10;
            bus.in_alu = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
            repeat (3) begin
                @(negedge clk);
                chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            end
            @(negedge clk);
            chk("retire_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
        end
        issue(WB_IMM, 4'd11, 16'h0, 16'h1234, ZERO, ZERO,
              {16'h1234, 16'h1234, 16'h1234, 16'h1234}, "b2b_imm");
        drain("t5");

        // 6. reset in the middle of a store
        issue(WB_STORE, 4'd3, 16'h0020, 16'h0, ZERO, ST20A, ZERO, "store20");
        drain("t6a");
        bus.in_src   = WB_STORE;
        bus.in_addr  = 16'h0020;
        bus.in_store = ST20B;
        bus.in_valid = 1'b1;
        @(posedge clk);              // acceptance edge
        #1 bus.in_valid = 1'b0;
        @(posedge clk);              // beat 0 written
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_wb_data",   64'(bus.wb_data),   64'd0);
        exp_last = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("post_abort_out_valid", 64'(bus.out_valid), 64'd0);
        issue(WB_MEM, 4'd12, 16'h0020, 16'h0, ZERO, ZERO, LOAD20, "load20");
        drain("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
